// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequencer that replays a small program store into the bit8ALU command
//   port. Each instruction is fetched, issued with alu_write high, held for
//   WAIT_CYCLES cycles, then the ALU result is captured into a result log
//   (last result, carry count, XOR checksum).
//
// Ports
//   clk, rst_n       : system clock (rising edge), async active-low reset
//   prog_we/addr/data: program store write port (IDLE/DONE only)
//   prog_len, start  : run request; prog_len sampled with start in IDLE
//   busy, done       : run status; done is a one-cycle end-of-run pulse
//   alu_*            : command fields to the ALU, zero when not issuing
//   alu_zout/carry   : ALU result, sampled in CAPTURE
//   issued_cnt, carry_cnt, checksum, last_zout : result log
module alu_issue_ctrl #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [22:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [3:0]    alu_addr1,
    output logic [3:0]    alu_addr2,
    output logic [3:0]    alu_rd,
    output logic [2:0]    alu_func,
    output logic [7:0]    alu_memaddr,
    output logic          alu_write,
    input  logic [7:0]    alu_zout,
    input  logic          alu_carry,
    output logic [AW:0]   issued_cnt,
    output logic [AW:0]   carry_cnt,
    output logic [7:0]    checksum,
    output logic [7:0]    last_zout
);

    typedef struct packed {
        logic [2:0] func;
        logic [3:0] addr1;
        logic [3:0] addr2;
        logic [3:0] rd;
        logic [7:0] memaddr;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [2:0]  W_LAST  = 3'(WAIT_CYCLES - 1);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t        state, state_nx;
    instr_t        store [DEPTH];
    instr_t        instr_q;
    logic [AW-1:0] pc;
    logic [AW:0]   len_q;
    logic [2:0]    wcnt;
    logic          last_instr;
    logic          drive;
    logic [AW:0]   len_clamped;

    assign len_clamped = (prog_len > DEPTH_V) ? DEPTH_V : prog_len;
    assign last_instr  = ({1'b0, pc} == (len_q - ONE));

    // Program store: no reset so a mid-run abort keeps the loaded program.
    // Writes are accepted only while no program is running.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE || state == S_DONE))
            store[prog_addr] <= instr_t'(prog_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = (prog_len == '0) ? S_DONE : S_FETCH;
            S_FETCH:   state_nx = S_ISSUE;
            S_ISSUE:   state_nx = S_WAIT;
            S_WAIT:    if (wcnt == W_LAST) state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = last_instr ? S_DONE : S_FETCH;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            len_q      <= '0;
            wcnt       <= '0;
            instr_q    <= '0;
            issued_cnt <= '0;
            carry_cnt  <= '0;
            checksum   <= '0;
            last_zout  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A zero-length start also clears the log before DONE.
                    if (start) begin
                        len_q      <= len_clamped;
                        pc         <= '0;
                        issued_cnt <= '0;
                        carry_cnt  <= '0;
                        checksum   <= '0;
                        last_zout  <= '0;
                    end
                end
                S_FETCH: instr_q <= store[pc];
                S_ISSUE: wcnt <= '0;
                S_WAIT:  wcnt <= wcnt + 3'd1;
                S_CAPTURE: begin
                    last_zout  <= alu_zout;
                    checksum   <= checksum ^ alu_zout;
                    issued_cnt <= issued_cnt + ONE;
                    if (alu_carry) carry_cnt <= carry_cnt + ONE;
                    if (!last_instr) pc <= pc + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Command fields are gated by state so they fall to zero asynchronously
    // on reset and outside the issue/hold/capture window.
    assign drive = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CAPTURE);

    always_comb begin
        alu_func    = '0;
        alu_addr1   = '0;
        alu_addr2   = '0;
        alu_rd      = '0;
        alu_memaddr = '0;
        if (drive) begin
            alu_func    = instr_q.func;
            alu_addr1   = instr_q.addr1;
            alu_addr2   = instr_q.addr2;
            alu_rd      = instr_q.rd;
            alu_memaddr = instr_q.memaddr;
        end
    end

    // Write is dropped in CAPTURE so the ALU result is stable when sampled.
    assign alu_write = (state == S_ISSUE) || (state == S_WAIT);
    assign busy      = (state == S_FETCH) || drive;
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int W     = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [22:0]   prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          busy, done;
    logic [3:0]    alu_addr1, alu_addr2, alu_rd;
    logic [2:0]    alu_func;
    logic [7:0]    alu_memaddr;
    logic          alu_write;
    logic [7:0]    alu_zout;
    logic          alu_carry;
    logic [AW:0]   issued_cnt, carry_cnt;
    logic [7:0]    checksum, last_zout;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  regbank [16];
    logic [22:0] mstore  [16];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len(prog_len), .start(start), .busy(busy), .done(done),
        .alu_addr1(alu_addr1), .alu_addr2(alu_addr2), .alu_rd(alu_rd),
        .alu_func(alu_func), .alu_memaddr(alu_memaddr), .alu_write(alu_write),
        .alu_zout(alu_zout), .alu_carry(alu_carry),
        .issued_cnt(issued_cnt), .carry_cnt(carry_cnt),
        .checksum(checksum), .last_zout(last_zout)
    );

    // 8-bit ALU behaviour: {carry/borrow, result}
    function automatic logic [8:0] alu_ref(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {(a < b), 8'(a - b)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {1'b0, ~b};
            default: return {1'b0, a} + 9'd1;
        endcase
    endfunction

    always_comb {alu_carry, alu_zout} = alu_ref(alu_func, regbank[alu_addr1], regbank[alu_addr2]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_instr(input int a, input logic [22:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
        mstore[a] = d;
    endtask

    // mode 0: plain run, 1: start/prog_we pulsed mid-run, 2: reset during WAIT of instr 3
    task automatic run_prog(input int plen, input int mode);
        int eff, budget, dcyc, dn, wr, bz, k, wk, cc;
        logic [7:0]  ez [16];
        logic [7:0]  xs, lz;
        logic [8:0]  r;
        logic [AW:0] prev;
        logic        pw;
        eff = (plen > DEPTH) ? DEPTH : plen;
        xs = 0; lz = 0; cc = 0;
        for (int i = 0; i < eff; i++) begin
            r = alu_ref(mstore[i][22:20], regbank[mstore[i][19:16]], regbank[mstore[i][15:12]]);
            ez[i] = r[7:0]; xs ^= r[7:0]; lz = r[7:0]; cc += int'(r[8]);
        end
        @(negedge clk);
        prog_len = (AW+1)'(plen); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcyc = -1; dn = 0; wr = 0; bz = 0; k = 0; wk = 0; prev = '0; pw = 1'b0;
        budget = eff * (W + 3) + 8;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (mode == 2 && c == 13) begin
                check("abort_in_wait", 32'(alu_write), 1);
                rst_n = 1'b0; #1;
                check("abort_outputs_zero", 32'({busy, done, alu_write, alu_func, alu_addr1,
                      alu_addr2, alu_rd, alu_memaddr}), 0);
                check("abort_log_zero", {issued_cnt, carry_cnt, checksum, last_zout}, 0);
                for (int j = 0; j < 3; j++) begin @(negedge clk); check("abort_no_done", 32'(done), 0); end
                rst_n = 1'b1;
                for (int j = 0; j < 3; j++) begin @(negedge clk); check("abort_idle", 32'({busy, done}), 0); end
                return;
            end
            if (alu_write && !pw) begin
                if (wk < eff)
                    check("issue_fields", 32'({alu_func, alu_addr1, alu_addr2, alu_rd, alu_memaddr}),
                          32'(mstore[wk]));
                wk++;
            end
            pw = alu_write;
            if (alu_write) wr++;
            if (busy) bz++;
            if (issued_cnt != prev) begin
                check("capture_step", 32'(issued_cnt), 32'(prev) + 1);
                if (k < 16) check("capture_zout", 32'(last_zout), 32'(ez[k]));
                k++;
                prev = issued_cnt;
            end
            if (done) begin
                dn++;
                if (dcyc < 0) dcyc = c;
                check("done_alu_idle", 32'({alu_write, alu_func, alu_addr1, alu_addr2, alu_rd, alu_memaddr}), 0);
            end
            if (mode == 1 && c == 4) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = AW'(1); prog_data = 23'h7FFFFF;
            end
            if (mode == 1 && c == 5) begin
                start = 1'b0; prog_we = 1'b0;
            end
            if (dcyc >= 0 && c >= dcyc + 2) break;
        end
        check("done_cycle", dcyc, eff * (W + 3) + 1);
        check("done_pulses", dn, 1);
        check("write_cycles", wr, eff * (W + 1));
        check("busy_cycles", bz, eff * (W + 3));
        check("issued_cnt", 32'(issued_cnt), eff);
        check("carry_cnt", 32'(carry_cnt), cc);
        check("checksum", 32'(checksum), 32'(xs));
        check("last_zout", 32'(last_zout), 32'(lz));
    endtask

    typedef struct {
        logic [2:0] f;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] z;
        logic       c;
    } vec_t;
    vec_t vt [11];

    initial begin
        vt[0]  = '{3'd0, 8'd3,    8'd5,    8'd8,    1'b0};
        vt[1]  = '{3'd0, 8'd255,  8'd1,    8'd0,    1'b1};
        vt[2]  = '{3'd1, 8'd5,    8'd3,    8'd2,    1'b0};
        vt[3]  = '{3'd1, 8'd3,    8'd5,    8'd254,  1'b1};
        vt[4]  = '{3'd2, 8'hF0,   8'h3C,   8'h30,   1'b0};
        vt[5]  = '{3'd3, 8'hF0,   8'h0F,   8'hFF,   1'b0};
        vt[6]  = '{3'd4, 8'hAA,   8'hFF,   8'h55,   1'b0};
        vt[7]  = '{3'd5, 8'h0F,   8'h00,   8'hF0,   1'b0};
        vt[8]  = '{3'd6, 8'h00,   8'h33,   8'hCC,   1'b0};
        vt[9]  = '{3'd7, 8'hFF,   8'h00,   8'h00,   1'b1};
        vt[10] = '{3'd7, 8'h41,   8'h00,   8'h42,   1'b0};

        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0;
        for (int i = 0; i < 16; i++) begin regbank[i] = 8'(i); mstore[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_status", 32'({busy, done}), 0);
        check("reset_alu", 32'({alu_write, alu_func, alu_addr1, alu_addr2, alu_rd, alu_memaddr}), 0);
        check("reset_log", {issued_cnt, carry_cnt, checksum, last_zout}, 0);

        // single ADD r3+r5
        write_instr(0, {3'd0, 4'd3, 4'd5, 4'd10, 8'd225});
        run_prog(1, 0);
        check("add_last", 32'(last_zout), 8);
        check("add_sum", 32'(checksum), 8);
        check("add_carry", 32'(carry_cnt), 0);

        // eight-op program, one of each function
        for (int i = 0; i < 8; i++)
            write_instr(i, {3'(i), 4'(i + 2), 4'(i + 1), 4'(i + 8), 8'(225 + i)});
        run_prog(8, 0);
        check("eight_issued", 32'(issued_cnt), 8);

        // table of single-instruction vectors with hand-computed results
        for (int v = 0; v < 11; v++) begin
            regbank[1] = vt[v].a; regbank[2] = vt[v].b;
            write_instr(0, {vt[v].f, 4'd1, 4'd2, 4'd3, 8'd225});
            run_prog(1, 0);
            check("vec_zout", 32'(last_zout), 32'(vt[v].z));
            check("vec_carry", 32'(carry_cnt), 32'(vt[v].c));
        end
        for (int i = 0; i < 16; i++) regbank[i] = 8'(i);

        // zero-length run clears the log left by the previous run
        run_prog(0, 0);

        // start and prog_we during a run are both dropped
        write_instr(1, {3'd0, 4'd4, 4'd6, 4'd0, 8'd1});
        run_prog(3, 1);
        run_prog(2, 0);

        // randomized programs and register contents; one over-length request
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) regbank[i] = 8'($urandom);
            for (int i = 0; i < 16; i++) write_instr(i, 23'($urandom));
            run_prog((t == 0) ? 20 : int'($urandom_range(1, 20)), 0);
        end

        // reset during WAIT of the third instruction, then restart
        run_prog(4, 2);
        run_prog(2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
